// File: rtl/slot_watchdog_pkg.sv
`default_nettype none
// ============================================================================
// Module : slot_watchdog_pkg
// Brief  : Shared constants and state encoding for the per-slot watchdog.
// Rev    : 1.0  initial release
// ============================================================================
package slot_watchdog_pkg;

    localparam int NSLOTS = 4;

    localparam logic [15:0] OFS_CTRL   = 16'h0000;
    localparam logic [15:0] OFS_RELOAD = 16'h0002;
    localparam logic [15:0] OFS_KICK   = 16'h0004;
    localparam logic [15:0] OFS_KILL   = 16'h0006;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } wd_state_e;

endpackage
`default_nettype wire

// File: rtl/slot_watchdog_if.sv
`default_nettype none
// ============================================================================
// Module : slot_watchdog_if
// Brief  : Core IO bus as seen by the watchdog (core = master).
// Rev    : 1.0  initial release
// ============================================================================
interface slot_watchdog_if;
    logic        io_wr;
    logic        io_rd;
    logic [1:0]  io_slot;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    modport master (output io_wr, io_rd, io_slot, io_addr, io_wdata, input io_rdata);
    modport slave  (input io_wr, io_rd, io_slot, io_addr, io_wdata, output io_rdata);
endinterface
`default_nettype wire

// File: rtl/slot_wd_counter.sv
`default_nettype none
// ============================================================================
// Module : slot_wd_counter
// Brief  : One slot's watchdog FSM and down-counter.
// Rev    : 1.0  initial release
// ============================================================================
module slot_wd_counter
    import slot_watchdog_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] RELOAD_RST = {CNT_W{1'b1}}
) (
    input  wire logic             clk,
    input  wire logic             resetq,
    input  wire logic             enable_i,
    input  wire logic             kick_i,
    input  wire logic             active_i,
    input  wire logic [CNT_W-1:0] reload_i,
    output logic                  fire_o,
    output logic [1:0]            state_o
);

    wd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_OFF;
            cnt_q   <= RELOAD_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority inside ARMED: disable, then kick, then the slot's own turn.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d = reload_i;
                if (enable_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable_i) begin
                    state_d = ST_OFF;
                    cnt_d   = reload_i;
                end else if (kick_i) begin
                    cnt_d = reload_i;
                end else if (active_i) begin
                    if (cnt_q == '0) state_d = ST_FIRE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_FIRE: begin
                cnt_d   = reload_i;
                state_d = enable_i ? ST_ARMED : ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = reload_i;
            end
        endcase
    end

    assign fire_o  = (state_q == ST_FIRE);
    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/slot_watchdog.sv
`default_nettype none
// ============================================================================
// Module : slot_watchdog
// Brief  : Per-slot watchdog for the 4-slot barrel core; IO decode and kill.
// Rev    : 1.0  initial release
// ============================================================================
module slot_watchdog
    import slot_watchdog_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter logic [15:0]      BASE_ADDR  = 16'h0400,
    parameter logic [CNT_W-1:0] RELOAD_RST = {CNT_W{1'b1}}
) (
    input  wire logic               clk,
    input  wire logic               resetq,
    slot_watchdog_if.slave          bus,
    output logic [NSLOTS-1:0]       kill_slot_rq,
    output logic [NSLOTS-1:0]       fired
);

    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + OFS_CTRL;
    localparam logic [15:0] ADDR_RELOAD = BASE_ADDR + OFS_RELOAD;
    localparam logic [15:0] ADDR_KICK   = BASE_ADDR + OFS_KICK;
    localparam logic [15:0] ADDR_KILL   = BASE_ADDR + OFS_KILL;

    logic                  wr_ctrl, wr_reload, wr_kick, wr_kill, rd_ctrl;
    logic [NSLOTS-1:0]     enable_q, fired_q, fired_d, kill_q, fire_vec, clr_vec;
    logic [CNT_W-1:0]      reload_q;
    logic [15:0]           rdata_q;
    logic [2*NSLOTS-1:0]   state_bits;

    assign wr_ctrl   = bus.io_wr && (bus.io_addr == ADDR_CTRL);
    assign wr_reload = bus.io_wr && (bus.io_addr == ADDR_RELOAD);
    assign wr_kick   = bus.io_wr && (bus.io_addr == ADDR_KICK);
    assign wr_kill   = bus.io_wr && (bus.io_addr == ADDR_KILL);
    assign rd_ctrl   = bus.io_rd && (bus.io_addr == ADDR_CTRL);

    generate
        for (genvar n = 0; n < NSLOTS; n++) begin : g_slot
            slot_wd_counter #(
                .CNT_W      (CNT_W),
                .RELOAD_RST (RELOAD_RST)
            ) u_cnt (
                .clk      (clk),
                .resetq   (resetq),
                .enable_i (enable_q[n]),
                .kick_i   (wr_kick && (bus.io_slot == 2'(n))),
                .active_i (bus.io_slot == 2'(n)),
                .reload_i (reload_q),
                .fire_o   (fire_vec[n]),
                .state_o  (state_bits[2*n +: 2])
            );
        end
    endgenerate

    // A fire in the same clock as a clear request keeps the flag set.
    assign clr_vec = wr_ctrl ? bus.io_wdata[7:4] : '0;
    assign fired_d = (fired_q & ~clr_vec) | fire_vec;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            enable_q <= '0;
            fired_q  <= '0;
            kill_q   <= '0;
            reload_q <= RELOAD_RST;
            rdata_q  <= '0;
        end else begin
            fired_q <= fired_d;
            kill_q  <= wr_kill ? bus.io_wdata[NSLOTS-1:0] : '0;
            if (wr_ctrl)   enable_q <= bus.io_wdata[NSLOTS-1:0];
            if (wr_reload) reload_q <= bus.io_wdata[CNT_W-1:0];
            if (rd_ctrl)   rdata_q  <= {4'b0000, state_bits, fired_q};
        end
    end

    assign kill_slot_rq = fire_vec | kill_q;
    assign fired        = fired_q;
    assign bus.io_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_watchdog.sv
`default_nettype none
// ============================================================================
// Module : tb_slot_watchdog
// Brief  : Scoreboard bench for slot_watchdog with a cycle reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_slot_watchdog;

    localparam logic [15:0] BASE = 16'h0400;

    typedef struct {
        logic [3:0]  kill;
        logic [3:0]  fired;
        logic [15:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic [3:0] kill_slot_rq;
    logic [3:0] fired;

    slot_watchdog_if bus();

    slot_watchdog #(
        .CNT_W      (16),
        .BASE_ADDR  (BASE),
        .RELOAD_RST (16'hFFFF)
    ) dut (
        .clk          (clk),
        .resetq       (resetq),
        .bus          (bus),
        .kill_slot_rq (kill_slot_rq),
        .fired        (fired)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   cur_slot = 0;

    // Reference: per slot, mode 0=off 1=watching 2=firing, and how many more
    // of its own turns it may pass before it times out.
    logic [1:0]  m_mode[4];
    int          m_left[4];
    logic [3:0]  m_en, m_fired, m_kill;
    int          m_rel;
    logic [15:0] m_rdata;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] fire_now, kick, clr;
        bit   w_ctrl, w_rel, w_kick, w_kill;
        exp_t e;
        if (!resetq) begin
            for (int n = 0; n < 4; n++) begin m_mode[n] = 2'd0; m_left[n] = 65535; end
            m_en = 0; m_fired = 0; m_kill = 0; m_rel = 65535; m_rdata = 0;
        end else begin
            w_ctrl = bus.io_wr && bus.io_addr == BASE;
            w_rel  = bus.io_wr && bus.io_addr == BASE + 16'd2;
            w_kick = bus.io_wr && bus.io_addr == BASE + 16'd4;
            w_kill = bus.io_wr && bus.io_addr == BASE + 16'd6;
            for (int n = 0; n < 4; n++) begin
                fire_now[n] = (m_mode[n] == 2'd2);
                kick[n]     = w_kick && (int'(bus.io_slot) == n);
            end
            if (bus.io_rd && bus.io_addr == BASE)
                m_rdata = {4'b0, m_mode[3], m_mode[2], m_mode[1], m_mode[0], m_fired};
            clr = w_ctrl ? bus.io_wdata[7:4] : 4'b0;
            m_fired = (m_fired & ~clr) | fire_now;
            for (int n = 0; n < 4; n++) begin
                if (m_mode[n] == 2'd2 || !m_en[n]) begin
                    m_left[n] = m_rel;
                    m_mode[n] = m_en[n] ? 2'd1 : 2'd0;
                end else if (m_mode[n] == 2'd0 || kick[n]) begin
                    m_left[n] = m_rel;
                    m_mode[n] = 2'd1;
                end else if (int'(bus.io_slot) == n) begin
                    if (m_left[n] == 0) m_mode[n] = 2'd2;
                    else                m_left[n] = m_left[n] - 1;
                end
            end
            m_kill = w_kill ? bus.io_wdata[3:0] : 4'b0;
            if (w_ctrl) m_en  = bus.io_wdata[3:0];
            if (w_rel)  m_rel = int'(bus.io_wdata);
        end
        for (int n = 0; n < 4; n++) e.kill[n] = (m_mode[n] == 2'd2) | m_kill[n];
        e.fired = m_fired;
        e.rdata = m_rdata;
        exp_q.push_back(e);
    endtask

    // One bus cycle: present inputs, let the edge happen, record expectation.
    task automatic cyc(bit wr, bit rd, logic [15:0] addr, logic [15:0] data);
        bus.io_wr    = wr;
        bus.io_rd    = rd;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_slot  = 2'(cur_slot);
        @(posedge clk);
        model_step();
        #1;
        cur_slot = (cur_slot + 1) % 4;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0000, 16'h0000);
    endtask

    task automatic wr_as(int slot, logic [15:0] ofs, logic [15:0] data);
        while (cur_slot != slot) idle(1);
        cyc(1, 0, BASE + ofs, data);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("kill_slot_rq", {12'h0, kill_slot_rq}, {12'h0, e.kill});
                check("fired",        {12'h0, fired},        {12'h0, e.fired});
                check("io_rdata",     bus.io_rdata,          e.rdata);
            end
        end
    end

    initial begin : driver
        int r;
        int guard;
        bus.io_wr = 0; bus.io_rd = 0; bus.io_slot = 0; bus.io_addr = 0; bus.io_wdata = 0;
        idle(2);
        resetq = 1'b1;
        cyc(0, 1, BASE, 16'h0000);
        idle(1000);

        wr_as(0, 16'h2, 16'd3);
        wr_as(0, 16'h0, 16'h0001);
        idle(60);
        cyc(0, 1, BASE, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            wr_as(0, 16'h4, 16'h0000);
            idle(11);
        end
        idle(40);

        wr_as(2, 16'h6, 16'h0008);
        idle(6);

        // Kick lands exactly on the expiry turn every time.
        for (int k = 0; k < 6; k++) begin
            wr_as(0, 16'h4, 16'h0000);
            idle(15);
        end
        wr_as(0, 16'h0, 16'h0010);
        cyc(0, 1, BASE, 16'h0000);
        idle(3);

        wr_as(1, 16'h2, 16'd1);
        wr_as(1, 16'h0, 16'h0002);
        guard = 0;
        while (m_mode[1] != 2'd2 && guard < 200) begin idle(1); guard++; end
        if (guard >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL fire_wait: got no FIRE on slot 1 expected one within 200 clocks");
        end else begin
            @(negedge clk);
            #1 resetq = 1'b0;
            #1;
            check("async_kill", {12'h0, kill_slot_rq}, 16'h0000);
            check("async_fired", {12'h0, fired}, 16'h0000);
            idle(2);
            resetq = 1'b1;
            cyc(0, 1, BASE, 16'h0000);
            idle(2);
        end

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 4)  cyc(1, 0, BASE + 16'd2, 16'($urandom_range(0, 6)));
            else if (r < 7)  cyc(1, 0, BASE, {8'h00, 4'($urandom), 4'($urandom)});
            else if (r < 15) cyc(1, 0, BASE + 16'd4, 16'($urandom));
            else if (r < 17) cyc(1, 0, BASE + 16'd6, 16'($urandom));
            else if (r < 19) cyc(1, 0, BASE + 16'($urandom_range(1, 9)) * 16'd1 + 16'h0100, 16'($urandom));
            else if (r < 30) cyc(0, 1, BASE, 16'h0000);
            else if (r < 32) cyc(0, 1, BASE + 16'd2, 16'h0000);
            else             idle(1);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
